// File: rtl/div_ctrl_if.sv
// Bundle of the pipeline request/result signals and the divider handshake seen by div_ctrl.
// master is the environment (EX stage plus divider), slave is the sequencer.
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             op_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             done;
    logic             hi_lo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dv_start;
    logic [WIDTH-1:0] dv_dividend;
    logic [WIDTH-1:0] dv_divisor;
    logic             dv_busy;
    logic [WIDTH-1:0] dv_q;
    logic [WIDTH-1:0] dv_r;

    modport master (
        output req, op_signed, a, b, flush, dv_busy, dv_q, dv_r,
        input  stall, done, hi_lo_we, hi, lo, dv_start, dv_dividend, dv_divisor
    );

    modport slave (
        input  req, op_signed, a, b, flush, dv_busy, dv_q, dv_r,
        output stall, done, hi_lo_we, hi, lo, dv_start, dv_dividend, dv_divisor
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer between EX and the shared unsigned iterative divider: magnitude conversion,
// start/busy handshake, sign correction of quotient/remainder, stall and flush handling.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    div_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, WAIT, DONE, DRAIN} state_t;

    state_t           state_q, state_d;
    logic             op_signed_q, op_signed_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             abort_q, abort_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             stall_c, done_c, we_c, start_c;
    logic             negate_quot, negate_rem;

    // Quotient sign follows both operands, remainder sign follows the dividend
    assign negate_quot = op_signed_q & (sa_q ^ sb_q);
    assign negate_rem  = op_signed_q & sa_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_signed_q <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            abort_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_signed_q <= op_signed_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            abort_q     <= abort_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_signed_d = op_signed_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        abort_d     = abort_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        stall_c     = 1'b0;
        done_c      = 1'b0;
        we_c        = 1'b0;
        start_c     = 1'b0;

        case (state_q)
            IDLE: begin
                stall_c = bus.req;
                abort_d = 1'b0;
                if (bus.req && !bus.flush) begin
                    op_signed_d = bus.op_signed;
                    sa_d        = bus.a[WIDTH-1];
                    sb_d        = bus.b[WIDTH-1];
                    // Divide by zero bypasses the divider entirely
                    if (bus.b == '0) begin
                        lo_d    = '1;
                        hi_d    = bus.a;
                        state_d = DONE;
                    end else begin
                        dividend_d = (bus.op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                        divisor_d  = (bus.op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                        state_d    = START;
                    end
                end
            end
            START: begin
                stall_c = 1'b1;
                start_c = 1'b1;
                if (bus.flush) begin
                    abort_d = 1'b1;
                end
                // The handshake must complete even when aborting, so the divider is left clean
                if (bus.dv_busy) begin
                    state_d = (abort_q || bus.flush) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (bus.flush) begin
                    state_d = DRAIN;
                end else if (!bus.dv_busy) begin
                    lo_d    = negate_quot ? -bus.dv_q : bus.dv_q;
                    hi_d    = negate_rem  ? -bus.dv_r : bus.dv_r;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                we_c    = ~bus.flush;
                state_d = IDLE;
            end
            DRAIN: begin
                stall_c = 1'b1;
                if (!bus.dv_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.stall       = stall_c;
    assign bus.done        = done_c;
    assign bus.hi_lo_we    = we_c;
    assign bus.dv_start    = start_c;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.dv_dividend = dividend_q;
    assign bus.dv_divisor  = divisor_q;
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer between the EX stage and the shared 32-bit iterative unsigned divider. Accepts DIV/DIVU requests from the pipeline, converts signed operands to magnitudes, runs the divider through its start/busy handshake, sign-corrects the results and writes HI (remainder) / LO (quotient). Generates the pipeline stall for the whole operation and supports flush on exception without corrupting HI/LO or the divider.

## Interface
- WIDTH, 32, operand/result width (only 32 is supported)
- clock  in  1  rising-edge clock for this block
- reset  in  1  asynchronous, active-low reset
- req  in  1  EX holds a DIV/DIVU; held high until `done`
- op_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with `req`
- a  in  WIDTH  dividend; sampled on accept
- b  in  WIDTH  divisor; sampled on accept
- flush  in  1  abort current operation (exception/branch squash)
- stall  out  1  freeze the pipeline (combinational)
- done  out  1  one-cycle pulse; HI/LO outputs valid
- hi_lo_we  out  1  HI/LO register write enable (= done unless flushed)
- hi  out  WIDTH  remainder
- lo  out  WIDTH  quotient
- dv_start  out  1  start to divider
- dv_dividend  out  WIDTH  unsigned dividend to divider
- dv_divisor  out  WIDTH  unsigned divisor to divider
- dv_busy  in  1  divider busy
- dv_q  in  WIDTH  divider quotient
- dv_r  in  WIDTH  divider remainder (already restored, non-negative)

## Operation
- Reset (reset=0): state IDLE; stall, done, hi_lo_we, dv_start = 0; hi, lo, dv_dividend, dv_divisor, internal flags = 0.
- States: IDLE, START, WAIT, DONE, DRAIN.
- IDLE: on `req & ~flush`, accept: latch `op_signed`, sign of a (sa), sign of b (sb).
  - b == 0: lo = all ones, hi = a (signed and unsigned alike); go DONE. Divider not used.
  - else: dv_dividend = (op_signed & sa) ? -a : a; dv_divisor = (op_signed & sb) ? -b : b; go START.
- START: dv_start = 1 and held. On dv_busy = 1, go WAIT (or DRAIN if abort flag is set).
- WAIT: on dv_busy = 0, register lo = neg_q ? -dv_q : dv_q, hi = neg_r ? -dv_r : dv_r; go DONE. neg_q = op_signed & (sa ^ sb); neg_r = op_signed & sa.
- DONE: done = 1, hi_lo_we = ~flush; unconditionally go IDLE. `req` in DONE belongs to the finished instruction and is ignored.
- DRAIN: no writes; on dv_busy = 0 go IDLE.
- Negation is 32-bit two's complement modulo 2^32; INT_MIN / -1 gives lo = 0x80000000, hi = 0 with no special case.
- Operands and the divider inputs stay stable from accept until DONE/DRAIN exit.

## Timing
- stall = (state ∈ {START, WAIT, DRAIN}) | (state == IDLE & req). In DONE, stall = 0, so the pipeline advances on the DONE edge.
- Divide-by-zero latency: accept at cycle N (IDLE), DONE at N+1.
- Normal latency: accept at N, START from N+1 until busy is seen high, WAIT until busy is seen low, DONE one cycle later. With a 32-iteration divider this is about 35 cycles.
- Back-to-back: the next `req` is accepted in the IDLE cycle immediately after DONE.
- Flush handling:
  - In IDLE: request not accepted.
  - In START: set abort flag and complete the start handshake, then DRAIN.
  - In WAIT: go DRAIN.
  - In DONE: suppress hi_lo_we; `done` still pulses.
  - In DRAIN: no effect.
- A request pending during DRAIN stays stalled and is accepted only in the following IDLE.
- Reset asserted mid-operation forces IDLE immediately. The divider is reset by the same system reset.

## Test plan
- DIVU a=100, b=7 -> lo=14, hi=2; one `done` and one `hi_lo_we` pulse; stall high from accept until DONE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU with the same operands -> lo=0, hi=0x80000000.
- b=0, a=0x12345678 (DIV and DIVU) -> done at N+1, lo=0xFFFFFFFF, hi=0x12345678, dv_start never asserted.
- DIVU 1000/10 with flush pulsed 1 cycle in START and again mid-WAIT (separate runs) -> DRAIN until dv_busy=0, no hi_lo_we, hi/lo unchanged. A following DIVU 9/4 -> lo=2, hi=1.
- Two back-to-back requests (20/3 then -20/3 signed) -> results (6,2) then (0xFFFFFFFA, 0xFFFFFFFE); second accepted in the IDLE cycle right after the first DONE. Also drive reset low mid-WAIT -> all outputs 0, state IDLE.
